nios_v1_key_pio: RTL
====================

Name: nios_v1_key_pio

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the system's 7-bit output PIOs (hex displays), for push-buttons/switches feeding the Nios.
- Synchronises and debounces external inputs, exposes the stable level, latches edges in an edge-capture register, and raises a maskable level interrupt to the CPU.
- Sits on the same Avalon bus fabric as the output PIOs, same 2-bit word address space, zero-wait-state combinational reads.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive cycles an input must differ from the stable value before it is accepted (10 ms at 50 MHz); 0 = debounce bypassed.
- EDGE_TYPE, 1, which edges are captured: 0 rising, 1 falling, 2 any.
- IDLE_LEVEL, all-ones (WIDTH bits), reset value of the synchroniser and stable registers; matches active-low key idle level.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset_n, input, 1, synchronous active-low reset, sampled on rising clk.
- address, input, 2, Avalon word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data, combinational from address.
- in_port, input, WIDTH, asynchronous external inputs.
- irq, output, 1, level interrupt to the CPU.

Behaviour:
- Reset (reset_n low at a clk edge): sync1, sync2, stable <= IDLE_LEVEL; debounce counters <= 0; irq_mask <= 0; edge_cap <= 0. irq therefore reads 0 after reset. Reset mid-debounce discards the count. No edge is captured on reset release.
- Synchroniser: sync1 <= in_port; sync2 <= sync1. Two flops, no logic between them.
- Debounce, per bit i, with DEBOUNCE_CYCLES >= 1:
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - otherwise, cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i], cnt[i] <= 0.
  - otherwise: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1. Any glitch back to the stable value restarts the count.
- Debounce bypass (DEBOUNCE_CYCLES = 0): stable <= sync2 every cycle.
- Latency: an in_port change set up before clk edge 1 is visible in stable at edge 2+max(DEBOUNCE_CYCLES,1).
- Edge detect: computed from the next stable value versus the current one.
  - rise = next & ~cur; fall = ~next & cur.
  - The selected edge set (per EDGE_TYPE) is ORed into edge_cap in the same edge that stable updates.
- Register map (word address):
  - 0, data: read stable, zero-extended; writes ignored.
  - 1, reserved: reads 0; writes ignored.
  - 2, irq_mask: read/write bits [WIDTH-1:0]; upper bits read 0.
  - 3, edge_cap: read; a write clears each bit where writedata[i]=1 (write-1-to-clear).
- Write condition: chipselect && !write_n.
- Read: readdata = mux(address) with no chipselect gating, zero wait states.
- Simultaneous edge detect and W1C clear on the same bit: set wins, and the bit stays 1. Clears on other bits proceed.
- irq = |(edge_cap & irq_mask), combinational from registers.
  - Stays asserted until the CPU clears the relevant edge_cap bits or masks them.
  - Unmasking an already-captured bit raises irq the cycle after the mask write.
- No writable state outside addresses 2 and 3.

Decomposition:
- Package nios_v1_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2;
  - the clog2 helper.
- One sub-module, nios_v1_pio_debounce_bit: single-bit counter plus stable flop, with DEBOUNCE_CYCLES and IDLE_LEVEL parameters. It is instantiated WIDTH times in a generate loop.
- Synchroniser, edge logic and register file stay in the top.

Test Plan:
1. Reset, then hold in_port=4'hF with DEBOUNCE_CYCLES=4 -> read addr0 = 0x0000000F, addr3 = 0, irq=0.
2. DEBOUNCE_CYCLES=4, EDGE_TYPE=1: in_port[0] 1->0 before edge 1 -> addr0 = 0xE exactly from edge 6; addr3 = 0x1 from edge 6; irq stays 0 while mask=0. Write addr2=0x1 -> irq=1 the next cycle.
3. Glitch: in_port[1] low for 3 cycles then high, DEBOUNCE_CYCLES=4 -> stable and edge_cap unchanged; then low for 4 cycles -> stable[1]=0 and edge_cap[1]=1.
4. W1C: edge_cap=0x3, write addr3=0x1 -> edge_cap=0x2, irq follows the mask. Same-cycle new edge on bit0 during the clear -> edge_cap[0] remains 1.
5. EDGE_TYPE=2, DEBOUNCE_CYCLES=0: toggle in_port[2] 0->1->0 with 5-cycle gaps -> each toggle appears in addr0 3 edges later, and edge_cap[2] is set after the first toggle. Writes to addr0/addr1 do not alter any read value.
6. Assert reset_n low mid-debounce (counter=2) -> after release, stable=IDLE_LEVEL, edge_cap=0, mask=0, irq=0, and the count restarts from 0.

Source files
------------

// File: rtl/nios_v1_pio_pkg.sv
// Shared constants for the Nios PIO family: word address map, edge-capture
// selection codes and a constant-function clog2 used to size counters.
package nios_v1_pio_pkg;

    localparam int BUS_W  = 32;
    localparam int ADDR_W = 2;

    // Word address map shared with the output PIOs
    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    // Which stable-level transitions are latched into edge_cap
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/nios_v1_key_pio_if.sv
// Avalon-MM slave bus bundle for the key PIO: word address, select,
// active-low write strobe, write data and combinational read data.
interface nios_v1_key_pio_if;

    logic [nios_v1_pio_pkg::ADDR_W-1:0] address;
    logic                               chipselect;
    logic                               write_n;
    logic [nios_v1_pio_pkg::BUS_W-1:0]  writedata;
    logic [nios_v1_pio_pkg::BUS_W-1:0]  readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_v1_pio_debounce_bit.sv
// Single-bit debouncer: a candidate level must differ from the stable level
// for DEBOUNCE_CYCLES consecutive samples before it is accepted. Any sample
// equal to the stable level restarts the count. DEBOUNCE_CYCLES = 0 makes the
// stable flop a plain follower of the synchronised input.
// stable_next is exported so the parent can detect edges in the same cycle
// that the stable flop updates.
module nios_v1_pio_debounce_bit
    import nios_v1_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    output logic stable,
    output logic stable_next
);

    logic stable_reg;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_next = sample;
        end else begin : g_count
            localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // Count consecutive disagreeing samples; accept on the last one
            always_comb begin
                cnt_next    = cnt_reg;
                stable_next = stable_reg;
                if (sample == stable_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    stable_next = sample;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Counter register; reset drops any partial count
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    // Stable level register, starting at the idle level of the input
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_reg <= IDLE_LEVEL;
        end else begin
            stable_reg <= stable_next;
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/nios_v1_key_pio.sv
// Avalon-MM input PIO for push-buttons and switches. Inputs are brought into
// the clock domain through a two-flop synchroniser, debounced per bit, and
// the accepted level is readable at word 0. Selected transitions of the
// accepted level are latched in a write-1-to-clear edge-capture register,
// and a maskable level interrupt is raised while any unmasked bit is set.
module nios_v1_key_pio
    import nios_v1_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               EDGE_TYPE       = EDGE_FALL,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_v1_key_pio_if.slave    bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] irq_mask_next;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic             wr_en;
    logic             unused_wdata;

    // Two-flop synchroniser, no logic between the stages
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg <= IDLE_LEVEL;
            sync2_reg <= IDLE_LEVEL;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    // One debouncer per input bit
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_debounce
            nios_v1_pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL      (IDLE_LEVEL[gi])
            ) u_debounce (
                .clk         (clk),
                .reset_n     (reset_n),
                .sample      (sync2_reg[gi]),
                .stable      (stable_reg[gi]),
                .stable_next (stable_next[gi])
            );
        end
    endgenerate

    // Edges are taken between the current and the about-to-be-stored level
    assign rise     = stable_next & ~stable_reg;
    assign fall     = ~stable_next & stable_reg;
    assign edge_hit = (EDGE_TYPE == EDGE_RISE) ? rise :
                      (EDGE_TYPE == EDGE_FALL) ? fall :
                                                 (rise | fall);

    assign wr_en = bus.chipselect && !bus.write_n;

    // Register-file next state: mask is plain R/W, edge_cap is W1C with set priority
    always_comb begin
        irq_mask_next = irq_mask_reg;
        edge_cap_next = edge_cap_reg;
        if (wr_en && (bus.address == ADDR_IRQMASK)) begin
            irq_mask_next = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            edge_cap_next = edge_cap_reg & ~bus.writedata[WIDTH-1:0];
        end
        edge_cap_next = edge_cap_next | edge_hit;
    end

    // Mask and edge-capture registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask_reg <= '0;
            edge_cap_reg <= '0;
        end else begin
            irq_mask_reg <= irq_mask_next;
            edge_cap_reg <= edge_cap_next;
        end
    end

    // Zero-wait-state read mux, not gated by chipselect
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = BUS_W'(stable_reg);
            ADDR_DIR:     bus.readdata = '0;
            ADDR_IRQMASK: bus.readdata = BUS_W'(irq_mask_reg);
            ADDR_EDGECAP: bus.readdata = BUS_W'(edge_cap_reg);
            default:      bus.readdata = '0;
        endcase
    end

    assign irq = |(edge_cap_reg & irq_mask_reg);

    // Write-data bits above WIDTH have no destination
    assign unused_wdata = ^bus.writedata;

endmodule
